// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions used by the memory interface and its RAM.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous word RAM; registered read, no reset on contents.
module ram_sp #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_interface.sv
// MAR/MDR registers and fixed-latency read/write engine in front of the word RAM.
module memory_interface #(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WR_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] MDR_q,
    output logic [ADDR_W-1:0] MAR_q,
    output logic              busy,
    output logic              mem_ready,
    output logic              mem_err
);

    import cpu_pkg::*;

    localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned CNT_W   = ($clog2(MAX_LAT) > 0) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_CNT0 = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT0 = CNT_W'(WR_LAT - 1);

    mem_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;
    logic              mem_ready_q;
    logic              mem_err_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // RAM address follows MAR while idle so that rdata already holds the
    // accepted word by the time the read counter expires, even with RD_LAT=1.
    always_comb begin
        ram_addr = addr_q;
        ram_we   = 1'b0;
        if (state_q == IDLE) begin
            ram_addr = MAR_q;
        end
        if ((state_q == WR_WAIT) && (cnt_q == '0)) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            MAR_q       <= '0;
            MDR_q       <= '0;
            busy_q      <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MARin) begin
                        MAR_q <= bus_in[ADDR_W-1:0];
                    end
                    if (Read && (Write || !MDRin)) begin
                        mem_err_q <= 1'b1;
                    end else if (Read) begin
                        addr_q  <= MAR_q;
                        cnt_q   <= RD_CNT0;
                        busy_q  <= 1'b1;
                        state_q <= RD_WAIT;
                    end else if (Write) begin
                        addr_q  <= MAR_q;
                        wdata_q <= bus_in;
                        MDR_q   <= bus_in;
                        cnt_q   <= WR_CNT0;
                        busy_q  <= 1'b1;
                        state_q <= WR_WAIT;
                    end else if (MDRin) begin
                        MDR_q <= bus_in;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        MDR_q   <= ram_rdata;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_q      <= 1'b0;
                    mem_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_memory_interface.sv
// Randomized self-checking bench for memory_interface against a word-array model.
module tb_memory_interface;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 3;
    localparam int unsigned WL = 2;

    logic          clock = 1'b0;
    logic          clear;
    logic [DW-1:0] bus_in;
    logic          MARin, MDRin, Read, Write;
    logic [DW-1:0] MDR_q;
    logic [AW-1:0] MAR_q;
    logic          busy, mem_ready, mem_err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_mem [int];
    logic [AW-1:0] written [$];

    memory_interface #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (RL),
        .WR_LAT (WL)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .bus_in    (bus_in),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .Read      (Read),
        .Write     (Write),
        .MDR_q     (MDR_q),
        .MAR_q     (MAR_q),
        .busy      (busy),
        .mem_ready (mem_ready),
        .mem_err   (mem_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle_in();
        MARin  = 1'b0;
        MDRin  = 1'b0;
        Read   = 1'b0;
        Write  = 1'b0;
        bus_in = '0;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        clear = 1'b0;
        step();
        clear = 1'b1;
    endtask

    // Steps until mem_ready is seen; n = edges after the accept edge, 0 on timeout.
    task automatic wait_ready(output int unsigned n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (mem_ready === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic load_mar(input logic [DW-1:0] b);
        logic [AW-1:0] exp;
        exp    = b[AW-1:0];
        bus_in = b;
        MARin  = 1'b1;
        step();
        idle_in();
        checks++;
        if (MAR_q !== exp) begin
            errors++;
            $display("FAIL mar_load: MAR_q=%h expected %h", MAR_q, exp);
        end
    endtask

    task automatic do_write(input logic [DW-1:0] addr_bus, input logic [DW-1:0] data);
        int unsigned n;
        logic [AW-1:0] a;
        a = addr_bus[AW-1:0];
        load_mar(addr_bus);
        bus_in = data;
        Write  = 1'b1;
        step();
        idle_in();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy: busy=%b expected 1", busy);
        end
        wait_ready(n);
        checks++;
        if (n != WL + 1) begin
            errors++;
            $display("FAIL write_latency: got %0d cycles expected %0d (addr %h)", n, WL + 1, a);
        end
        checks++;
        if (MDR_q !== data || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_done: MDR_q=%h busy=%b expected %h busy=0", MDR_q, busy, data);
        end
        if (!ref_mem.exists(int'(a))) written.push_back(a);
        ref_mem[int'(a)] = data;
    endtask

    task automatic do_read(input logic [DW-1:0] addr_bus);
        int unsigned n;
        logic [AW-1:0] a;
        logic [DW-1:0] exp;
        a   = addr_bus[AW-1:0];
        exp = ref_mem[int'(a)];
        load_mar(addr_bus);
        bus_in = $urandom;
        MDRin  = 1'b1;
        Read   = 1'b1;
        step();
        idle_in();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL read_busy: busy=%b expected 1", busy);
        end
        wait_ready(n);
        checks++;
        if (n != RL + 1) begin
            errors++;
            $display("FAIL read_latency: got %0d cycles expected %0d (addr %h)", n, RL + 1, a);
        end
        checks++;
        if (MDR_q !== exp) begin
            errors++;
            $display("FAIL read_data: addr %h MDR_q=%h expected %h", a, MDR_q, exp);
        end
    endtask

    task automatic test_reset();
        idle_in();
        clear = 1'b0;
        #3;
        checks++;
        if ({MAR_q, MDR_q, busy, mem_ready, mem_err} !== '0) begin
            errors++;
            $display("FAIL reset_initial: MAR=%h MDR=%h busy=%b rdy=%b err=%b expected all 0",
                     MAR_q, MDR_q, busy, mem_ready, mem_err);
        end
        @(negedge clock);
        clear = 1'b1;
        step();
        // Build up non-zero state, then clear mid-access without any clock edge.
        do_write(32'h0000_0155, 32'h0BAD_F00D);
        Read = 1'b1;
        step();
        idle_in();
        checks++;
        if (mem_err !== 1'b1) begin
            errors++;
            $display("FAIL reset_prep_err: mem_err=%b expected 1", mem_err);
        end
        MDRin = 1'b1;
        Read  = 1'b1;
        step();
        idle_in();
        #2;
        clear = 1'b0;
        #1;
        checks++;
        if ({MAR_q, MDR_q, busy, mem_ready, mem_err} !== '0) begin
            errors++;
            $display("FAIL reset_async: MAR=%h MDR=%h busy=%b rdy=%b err=%b expected all 0",
                     MAR_q, MDR_q, busy, mem_ready, mem_err);
        end
        step();
        clear = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(32'h0000_005A, 32'hDEAD_BEEF);
        bus_in = '0;
        MDRin  = 1'b1;
        step();
        idle_in();
        checks++;
        if (MDR_q !== '0) begin
            errors++;
            $display("FAIL wr_rd_mdr_clear: MDR_q=%h expected 0", MDR_q);
        end
        do_read(32'h0000_005A);
    endtask

    task automatic test_plain_mdr();
        bus_in = 32'h1234_5678;
        MDRin  = 1'b1;
        step();
        idle_in();
        checks++;
        if (MDR_q !== 32'h1234_5678 || mem_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL plain_mdr: MDR_q=%h rdy=%b busy=%b expected 12345678 0 0",
                     MDR_q, mem_ready, busy);
        end
        step();
        checks++;
        if (mem_ready !== 1'b0 || MDR_q !== 32'h1234_5678) begin
            errors++;
            $display("FAIL plain_mdr_hold: rdy=%b MDR_q=%h expected 0 12345678", mem_ready, MDR_q);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] b;
        for (int i = 0; i < 24; i++) begin
            b = $urandom;
            if (written.size() == 0 || $urandom_range(1, 0) == 0) begin
                do_write(b, $urandom);
            end else begin
                b[AW-1:0] = written[$urandom_range(written.size() - 1, 0)];
                do_read(b);
            end
        end
    endtask

    task automatic test_mar_with_request();
        logic [DW-1:0] data;
        data = 32'h1357_0111;
        do_write(32'h0000_0111, 32'h5555_AAAA);
        do_write(32'h0000_00A0, 32'h0000_0001);
        bus_in = data;
        MARin  = 1'b1;
        Write  = 1'b1;
        step();
        idle_in();
        checks++;
        if (MAR_q !== 9'h111) begin
            errors++;
            $display("FAIL marw_mar: MAR_q=%h expected 111", MAR_q);
        end
        for (int i = 0; i < 10 && mem_ready !== 1'b1; i++) step();
        ref_mem[32'h0A0] = data;
        do_read(32'h0000_00A0);
        do_read(32'h0000_0111);
    endtask

    task automatic test_busy_ignore();
        int unsigned n;
        int pulses;
        do_write(32'h0000_0010, 32'hA1A1_0010);
        do_write(32'h0000_0020, 32'hB2B2_0020);
        load_mar(32'h0000_0010);
        MDRin = 1'b1;
        Read  = 1'b1;
        step();
        idle_in();
        bus_in = 32'h0000_0020;
        MARin  = 1'b1;
        Write  = 1'b1;
        MDRin  = 1'b1;
        wait_ready(n);
        idle_in();
        pulses = (n != 0) ? 1 : 0;
        checks++;
        if (n != RL + 1) begin
            errors++;
            $display("FAIL busy_latency: got %0d cycles expected %0d", n, RL + 1);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_ready === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL busy_pulses: saw %0d mem_ready pulses expected 1", pulses);
        end
        checks++;
        if (MAR_q !== 9'h010 || MDR_q !== 32'hA1A1_0010) begin
            errors++;
            $display("FAIL busy_hold: MAR_q=%h MDR_q=%h expected 010 a1a10010", MAR_q, MDR_q);
        end
        do_read(32'h0000_0020);
    endtask

    task automatic test_illegal();
        pulse_reset();
        load_mar(32'h0000_0010);
        bus_in = 32'hAAAA_5555;
        MDRin  = 1'b1;
        step();
        bus_in = 32'h0000_0BAD;
        Read   = 1'b1;
        Write  = 1'b1;
        step();
        idle_in();
        checks++;
        if (busy !== 1'b0 || mem_err !== 1'b1 || MDR_q !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL illegal_rw: busy=%b err=%b MDR_q=%h expected 0 1 aaaa5555",
                     busy, mem_err, MDR_q);
        end
        step();
        step();
        checks++;
        if (mem_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_noaccess: rdy=%b busy=%b expected 0 0", mem_ready, busy);
        end
        do_read(32'h0000_0010);
        checks++;
        if (mem_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: mem_err=%b expected 1", mem_err);
        end
        pulse_reset();
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: mem_err=%b expected 0", mem_err);
        end
        Read = 1'b1;
        step();
        idle_in();
        checks++;
        if (mem_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_read_nomdr: err=%b busy=%b expected 1 0", mem_err, busy);
        end
        pulse_reset();
    endtask

    task automatic test_abort_wrap();
        int pulses;
        pulses = 0;
        do_write(32'h0000_0003, 32'h0123_4567);
        load_mar(32'h0000_0203);
        bus_in = 32'h0000_CAFE;
        Write  = 1'b1;
        step();
        idle_in();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: busy=%b expected 1", busy);
        end
        #1;
        clear = 1'b0;
        for (int i = 0; i < int'(WL) + 2; i++) begin
            step();
            if (mem_ready === 1'b1) pulses++;
        end
        clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_ready === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_noready: pulses=%0d busy=%b expected 0 0", pulses, busy);
        end
        do_read(32'h0000_0003);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_plain_mdr();
        test_random();
        test_mar_with_request();
        test_busy_ignore();
        test_illegal();
        test_abort_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
